// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Shared definitions for the 64b/66b PCS scrambler datapath (TX scrambler and
// RX descrambler).
//   - Sync header encodings.
//   - Scrambler polynomial taps for x^58 + x^39 + 1 and the state width.
//   - pcs_word_t: one 32-bit payload word with its sync header. The skid buffer
//     and the output register both hold this type.
// -----------------------------------------------------------------------------
package pcs_pkg;

  // Sync header values produced by the 64b/66b encoder.
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Self-synchronous scrambler x^58 + x^39 + 1.
  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_STATE_W = 58;

  // Payload word width of this datapath.
  localparam int PCS_DATA_W  = 32;

  typedef struct packed {
    logic [1:0]            hdr;
    logic                  hdr_valid;
    logic [PCS_DATA_W-1:0] data;
  } pcs_word_t;

  // Build a word. The header field is forced to zero on non-header words so
  // that o_hdr never carries a stale or meaningless header downstream.
  function automatic pcs_word_t pcs_make_word(
    input logic [1:0]            hdr,
    input logic                  hdr_valid,
    input logic [PCS_DATA_W-1:0] data
  );
    pcs_word_t w;
    w.hdr       = hdr_valid ? hdr : 2'b00;
    w.hdr_valid = hdr_valid;
    w.data      = data;
    return w;
  endfunction

endpackage

// File: rtl/pcs_scrambler_core.sv
// -----------------------------------------------------------------------------
// pcs_scrambler_core
// Purely combinational 32-bit step of the self-synchronous scrambler
// x^58 + x^39 + 1. It processes bits 0..31 in order (bit 0 goes on the line
// first):
//   out_i = d_i ^ h_{i-39} ^ h_{i-58}
// Here h is the bit history. The history is the scrambled output when
// scrambling and the received input when descrambling.
//
// Ports:
//   state      in  58  history; bit 57 is the most recent bit, bit 0 the oldest
//   data       in  32  word to scramble/descramble
//   next_state out 58  history after this word
//   scr_data   out 32  scrambled (or descrambled) word
//
// Parameter:
//   DESCRAMBLE  0: the feedback is the output (TX scrambler)
//               1: the feedback is the input  (RX descrambler)
// -----------------------------------------------------------------------------
module pcs_scrambler_core
  import pcs_pkg::*;
#(
  parameter bit DESCRAMBLE = 1'b0
) (
  input  logic [SCR_STATE_W-1:0] state,
  input  logic [PCS_DATA_W-1:0]  data,
  output logic [SCR_STATE_W-1:0] next_state,
  output logic [PCS_DATA_W-1:0]  scr_data
);

  localparam int EXT_W = SCR_STATE_W + PCS_DATA_W;

  // Extended history. The low 58 bits are the incoming state. Each new bit is
  // appended above them, so bit i of this word sits at index SCR_STATE_W + i,
  // and "k bits ago" is index SCR_STATE_W + i - k.
  logic [EXT_W-1:0] hist;

  always_comb begin
    hist                   = '0;
    hist[SCR_STATE_W-1:0]  = state;
    scr_data               = '0;
    for (int i = 0; i < PCS_DATA_W; i++) begin
      scr_data[i] = data[i]
                  ^ hist[SCR_STATE_W + i - SCR_TAP_A]
                  ^ hist[SCR_STATE_W + i - SCR_TAP_B];
      hist[SCR_STATE_W + i] = DESCRAMBLE ? data[i] : scr_data[i];
    end
    next_state = hist[EXT_W-1 -: SCR_STATE_W];
  end

endmodule

// File: rtl/pcs_tx_scrambler.sv
// -----------------------------------------------------------------------------
// pcs_tx_scrambler
// 64b/66b TX scrambler with a 32-bit datapath. It sits between the 64b/66b
// encoder and the TX gearbox. The payload is scrambled with x^58 + x^39 + 1.
// The 2-bit sync header is not scrambled and travels alongside its word.
// A one-entry skid buffer and a registered pause absorb the gearbox's
// one-cycle pause. A sticky flag reports header/word misalignment.
//
// Ports:
//   i_clk         in   1   clock
//   i_reset       in   1   synchronous active-high reset
//   i_data        in  32   encoded payload word, LSB transmitted first
//   i_data_valid  in   1   word present; accepted when high and o_pause low
//   i_hdr         in   2   sync header, meaningful only with i_hdr_valid
//   i_hdr_valid   in   1   first (header-bearing) word of a 66b block
//   i_bypass      in   1   payload passes unscrambled; scrambler state holds
//   i_pause       in   1   gearbox pause: hold the output this cycle
//   o_pause       out  1   registered back-pressure to the encoder
//   o_data        out 32   scrambled word
//   o_data_valid  out  1   o_data valid
//   o_hdr         out  2   header aligned with o_data (0 on non-header words)
//   o_hdr_valid   out  1   o_data is the first word of a block
//   o_align_err   out  1   sticky alignment error
// -----------------------------------------------------------------------------
module pcs_tx_scrambler
  import pcs_pkg::*;
#(
  parameter int                     DATA_WIDTH = 32,
  parameter logic [SCR_STATE_W-1:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic [1:0]            i_hdr,
  input  logic                  i_hdr_valid,
  input  logic                  i_bypass,
  input  logic                  i_pause,
  output logic                  o_pause,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic [1:0]            o_hdr,
  output logic                  o_hdr_valid,
  output logic                  o_align_err
);

  // The scrambler core and the word struct are built for 32 bits only.
  if (DATA_WIDTH != PCS_DATA_W) begin : g_bad_width
    $error("pcs_tx_scrambler supports DATA_WIDTH == 32 only");
  end

  logic                   accept;
  logic [SCR_STATE_W-1:0] scr_state_p1;
  logic [SCR_STATE_W-1:0] scr_next_state;
  logic [PCS_DATA_W-1:0]  scr_data;
  pcs_word_t              in_word_p0;

  pcs_word_t              skid_word_p1;
  logic                   skid_vld_p1;
  logic                   skid_vld_next;

  pcs_word_t              out_word_p1;
  logic                   out_vld_p1;

  logic                   pause_p1;
  logic                   expect_hdr_p1;
  logic                   align_err_p1;

  assign accept = i_data_valid & ~pause_p1;

  // ---- stage p0: combinational scramble of the incoming word ----
  pcs_scrambler_core #(
    .DESCRAMBLE (1'b0)
  ) u_core (
    .state      (scr_state_p1),
    .data       (i_data),
    .next_state (scr_next_state),
    .scr_data   (scr_data)
  );

  // In bypass mode the raw word goes through. The state does not advance (see
  // below), so scrambling resumes exactly where it stopped.
  assign in_word_p0 = pcs_make_word(i_hdr, i_hdr_valid,
                                    i_bypass ? i_data : scr_data);

  // ---- stage p1: scrambler state, skid, output register, control ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scr_state_p1 <= SCR_SEED;
    end else if (accept && !i_bypass) begin
      scr_state_p1 <= scr_next_state;
    end
  end

  // Skid occupancy: any unpaused cycle empties it, either by draining it into
  // the output register or because it was already empty. A word accepted while
  // paused is parked here.
  always_comb begin
    skid_vld_next = skid_vld_p1;
    if (!i_pause) begin
      skid_vld_next = 1'b0;
    end else if (accept) begin
      skid_vld_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_pause && accept) begin
      skid_word_p1 <= in_word_p0;
    end
  end

  // The output register loads only when the gearbox is not pausing. The skid
  // has priority over the live input, which preserves word order. Because
  // o_pause is high whenever the skid is full, no new word can be accepted in
  // the same cycle as a drain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_word_p1 <= '0;
      out_vld_p1  <= 1'b0;
    end else if (!i_pause) begin
      if (skid_vld_p1) begin
        out_word_p1 <= skid_word_p1;
        out_vld_p1  <= 1'b1;
      end else if (accept) begin
        out_word_p1 <= in_word_p0;
        out_vld_p1  <= 1'b1;
      end else begin
        out_word_p1 <= '0;
        out_vld_p1  <= 1'b0;
      end
    end
  end

  // Back-pressure and alignment tracking. o_pause follows i_pause one cycle
  // later. It also stays high for the whole time the skid is occupied,
  // including the drain cycle, so the encoder cannot offer a word until the
  // skid has emptied into the output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      skid_vld_p1   <= 1'b0;
      pause_p1      <= 1'b0;
      expect_hdr_p1 <= 1'b1;
      align_err_p1  <= 1'b0;
    end else begin
      skid_vld_p1 <= skid_vld_next;
      pause_p1    <= i_pause | skid_vld_next | skid_vld_p1;
      if (accept) begin
        if (i_hdr_valid != expect_hdr_p1) begin
          align_err_p1 <= 1'b1;
        end
        // A block is two words. The next slot is the opposite of the word
        // just received. This also resynchronises the tracker after an error.
        expect_hdr_p1 <= ~i_hdr_valid;
      end
    end
  end

  // A word arriving while the skid is occupied would be lost.
  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(accept && skid_vld_p1));
    end
  end

  assign o_pause      = pause_p1;
  assign o_data       = out_word_p1.data;
  assign o_data_valid = out_vld_p1;
  assign o_hdr        = out_word_p1.hdr;
  assign o_hdr_valid  = out_word_p1.hdr_valid;
  assign o_align_err  = align_err_p1;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
module tb_pcs_tx_scrambler;
  import pcs_pkg::*;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic [1:0]  i_hdr = '0;
  logic        i_hdr_valid = 1'b0;
  logic        i_bypass = 1'b0;
  logic        i_pause = 1'b0;
  logic        o_pause;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_hdr;
  logic        o_hdr_valid;
  logic        o_align_err;

  pcs_tx_scrambler #(.DATA_WIDTH(32), .SCR_SEED(SEED)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_hdr(i_hdr), .i_hdr_valid(i_hdr_valid), .i_bypass(i_bypass), .i_pause(i_pause),
    .o_pause(o_pause), .o_data(o_data), .o_data_valid(o_data_valid), .o_hdr(o_hdr),
    .o_hdr_valid(o_hdr_valid), .o_align_err(o_align_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  hdr;
    logic        hv;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  bit   m_err;
  bit   m_exp_hdr;
  bit   last_acc;
  bit   drv_hdr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    logic [57:0] sd;
    sd = SEED;
    sb.delete();
    hist.delete();
    for (int j = 0; j < 58; j++) hist.push_back(sd[j]);
    m_err = 1'b0;
    m_exp_hdr = 1'b1;
  endtask

  // Reference scrambler: walk the line bit by bit. Each new bit is the data
  // bit XOR the scrambled bits sent 39 and 58 positions earlier.
  function automatic logic [31:0] ref_scramble(input logic [31:0] d);
    logic [31:0] r;
    bit s;
    for (int i = 0; i < 32; i++) begin
      s = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
      r[i] = s;
      hist.push_back(s);
      void'(hist.pop_front());
    end
    return r;
  endfunction

  // One clock: update the model from the inputs currently driven, then advance.
  task automatic cycle();
    exp_t e;
    exp_t w;
    if (i_reset) begin
      model_reset();
      last_acc = 1'b0;
    end else begin
      if (o_data_valid && !i_pause) begin
        chk("sb_expected_word", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          chk("sb_data", o_data, w.data);
          chk("sb_hdr", {o_hdr, o_hdr_valid}, {w.hdr, w.hv});
        end
      end
      last_acc = i_data_valid && !o_pause;
      if (last_acc) begin
        e.data = i_bypass ? i_data : ref_scramble(i_data);
        e.hdr  = i_hdr_valid ? i_hdr : 2'b00;
        e.hv   = i_hdr_valid;
        sb.push_back(e);
        if (i_hdr_valid != m_exp_hdr) m_err = 1'b1;
        m_exp_hdr = !i_hdr_valid;
      end
    end
    @(posedge i_clk);
    #1;
    chk("align_err_model", o_align_err, m_err);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_data_valid = 1'b0; i_pause = 1'b0; i_bypass = 1'b0;
    i_hdr_valid = 1'b0; i_hdr = 2'b00; i_data = '0;
    cycle();
    i_reset = 1'b0;
    drv_hdr = 1'b1;
  endtask

  task automatic drain();
    i_data_valid = 1'b0; i_pause = 1'b0;
    for (int k = 0; k < 8 && sb.size() != 0; k++) cycle();
    chk("drain_empty", sb.size(), 0);
    chk("drain_valid_low", o_data_valid, 0);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] h,
                       input logic hv, input logic byp, input logic p);
    i_data_valid = v; i_data = d; i_hdr = h; i_hdr_valid = hv; i_bypass = byp; i_pause = p;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_valid"}, o_data_valid, 0);
    chk({tag, "_hdr"}, o_hdr, 0);
    chk({tag, "_hdr_valid"}, o_hdr_valid, 0);
    chk({tag, "_align_err"}, o_align_err, 0);
    chk({tag, "_pause"}, o_pause, 0);
  endtask

  initial begin
    int idx;
    bit pulsed;
    int pcount;

    // Reset state
    model_reset();
    i_reset = 1'b1;
    cycle();
    cycle();
    chk_all_zero("reset");
    i_reset = 1'b0;

    // Zero payload after reset
    drive(1, 32'h0, SYNC_DATA, 1, 0, 0);
    cycle();
    chk("zero_w1_valid", o_data_valid, 1);
    chk("zero_w1_data", o_data, 32'h0000_0000);
    chk("zero_w1_hdr", o_hdr, SYNC_DATA);
    chk("zero_w1_hv", o_hdr_valid, 1);
    drive(1, 32'h0, 2'b11, 0, 0, 0);
    cycle();
    chk("zero_w2_data", o_data, 32'h03FF_FF80);
    chk("zero_w2_hv", o_hdr_valid, 0);
    chk("zero_w2_hdr", o_hdr, 0);
    drain();

    // Bypass, then resume scrambling from held (fresh) state
    do_reset();
    drive(1, 32'hDEAD_BEEF, SYNC_CTRL, 1, 1, 0);
    cycle();
    chk("bypass_data", o_data, 32'hDEAD_BEEF);
    chk("bypass_hdr", o_hdr, SYNC_CTRL);
    drive(1, 32'h0, 2'b00, 0, 0, 0);
    cycle();
    chk("post_bypass_data", o_data, 32'h0);
    drain();

    // Pause absorption: one-cycle pause while word 2 is offered
    do_reset();
    idx = 0; pulsed = 0; pcount = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      i_pause = (idx == 1 && !pulsed);
      if (i_pause) pulsed = 1;
      i_data_valid = 1'b1; i_data = idx + 1; i_hdr = SYNC_DATA; i_hdr_valid = (idx % 2 == 0);
      cycle();
      if (o_pause) pcount++;
      if (last_acc) idx++;
    end
    chk("pause_all_accepted", idx, 4);
    drain();
    if (o_pause) pcount++;
    chk("pause_o_pause_cycles", pcount, 2);
    chk("pause_align_err", o_align_err, 0);

    // Alternating pauses
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, $urandom, SYNC_DATA, drv_hdr, 0, (c % 2 == 0));
      cycle();
      if (last_acc) drv_hdr = !drv_hdr;
    end
    drain();
    chk("alt_pause_align_err", o_align_err, 0);

    // Randomized stream with random pauses and bypass between blocks
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_data_valid = ($urandom_range(0, 3) != 0);
      i_data = $urandom;
      i_hdr = $urandom_range(0, 1) ? SYNC_DATA : SYNC_CTRL;
      if (!drv_hdr) i_hdr = 2'($urandom_range(0, 3));
      i_hdr_valid = drv_hdr;
      if (drv_hdr && $urandom_range(0, 7) == 0) i_bypass = !i_bypass;
      i_pause = ($urandom_range(0, 3) == 0);
      cycle();
      if (last_acc) drv_hdr = !drv_hdr;
    end
    drain();
    chk("rand_align_err", o_align_err, 0);

    // Alignment error: two consecutive header words
    do_reset();
    drive(1, $urandom, SYNC_DATA, 1, 0, 0);
    cycle();
    chk("align_first_ok", o_align_err, 0);
    drive(1, $urandom, SYNC_DATA, 1, 0, 0);
    cycle();
    chk("align_err_set", o_align_err, 1);
    drive(1, $urandom, SYNC_DATA, 0, 0, 0);
    cycle();
    drive(1, $urandom, SYNC_DATA, 1, 0, 0);
    cycle();
    drain();
    chk("align_err_sticky", o_align_err, 1);
    do_reset();
    chk("align_err_cleared", o_align_err, 0);
    // Missing header in the first-word slot
    drive(1, $urandom, SYNC_DATA, 0, 0, 0);
    cycle();
    chk("align_missing_hdr", o_align_err, 1);
    drain();

    // Reset with the skid occupied
    do_reset();
    drive(1, 32'h1234_5678, SYNC_DATA, 1, 0, 0);
    cycle();
    drive(1, 32'h9ABC_DEF0, SYNC_DATA, 0, 0, 1);
    cycle();
    chk("skid_full_pause", o_pause, 1);
    do_reset();
    chk_all_zero("midreset");
    drive(1, 32'h0, SYNC_DATA, 1, 0, 0);
    cycle();
    chk("midreset_seed_valid", o_data_valid, 1);
    chk("midreset_seed_data", o_data, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
